// File: rtl/arm_mem_pkg.sv
// Shared definitions for the load/store unit: transfer-size codes,
// FSM state encoding, byte-lane masks and the alignment rule.
package arm_mem_pkg;

    localparam logic [1:0] DT_BYTE  = 2'b00;
    localparam logic [1:0] DT_HALF  = 2'b01;
    localparam logic [1:0] DT_WORD  = 2'b10;
    localparam logic [1:0] DT_DWORD = 2'b11;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_BEAT0,
        S_BEAT1,
        S_DONE,
        S_ERR
    } lsu_state_t;

    // Halfwords need even addresses; words and doublewords need
    // word-aligned addresses.
    function automatic logic misaligned(
        input logic [1:0] dt,
        input logic [1:0] off
    );
        logic bad;
        bad = 1'b0;
        case (dt)
            DT_HALF:  bad = off[0];
            DT_WORD:  bad = (off != 2'b00);
            DT_DWORD: bad = (off != 2'b00);
            default:  bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for one memory beat.
// LOAD=0: replicate store data across lanes and form byte enables.
// LOAD=1: extract the addressed byte/half and sign/zero-extend it.
// Ports:
//   dtype  transfer size code
//   off    byte offset within the word (addr[1:0])
//   sext   sign-extend narrow loads
//   din    store data (LOAD=0) or raw memory word (LOAD=1)
//   dout   lane-replicated store data or extended load data
//   be     byte enables (all lanes for loads)
module lsu_lane_align
    import arm_mem_pkg::*;
#(
    parameter bit LOAD = 1'b0
) (
    input  logic [1:0]  dtype,
    input  logic [1:0]  off,
    input  logic        sext,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic [3:0]  be
);

    logic [31:0] st_data;
    logic [3:0]  st_be;
    logic [31:0] ld_data;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v  = din[{off, 3'b000} +: 8];
        half_v  = din[{off[1], 4'b0000} +: 16];
        st_data = din;
        st_be   = BE_WORD;
        ld_data = din;
        case (dtype)
            DT_BYTE: begin
                st_data = {4{din[7:0]}};
                st_be   = BE_BYTE << off;
                ld_data = {{24{sext & byte_v[7]}}, byte_v};
            end
            DT_HALF: begin
                st_data = {2{din[15:0]}};
                st_be   = BE_HALF << off;
                ld_data = {{16{sext & half_v[15]}}, half_v};
            end
            default: begin
                st_data = din;
                st_be   = BE_WORD;
                ld_data = din;
            end
        endcase
    end

    assign dout = LOAD ? ld_data : st_data;
    assign be   = LOAD ? BE_WORD : st_be;

endmodule

// File: rtl/load_store_unit.sv
// Memory-access controller between CPU datapath and RAM: four-phase
// req/mfc toward control, single-beat en/ready toward memory.
// Ports:
//   clk, clr         clock, async active-low reset
//   req/rd/dtype     request, direction, size (sampled on accept)
//   sext/addr/wdata  extension mode, byte address, store data
//   mfc/err/rdata    completion, error flag, load result
//   busy             access in progress
//   mem_*            beat interface to RAM
module load_store_unit
    import arm_mem_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req,
    input  logic              rd,
    input  logic [1:0]        dtype,
    input  logic              sext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [63:0]       wdata,
    output logic              mfc,
    output logic              err,
    output logic [63:0]       rdata,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);

    localparam int CW = $clog2(TIMEOUT + 1);

    lsu_state_t        state;
    lsu_state_t        state_n;
    logic              rd_q;
    logic [1:0]        dtype_q;
    logic              sext_q;
    logic [ADDR_W-1:0] addr_q;
    logic [63:0]       wdata_q;
    logic [63:0]       rdata_q;
    logic [CW-1:0]     wait_cnt;
    logic              mfc_q;
    logic              err_q;
    logic              busy_q;

    logic              in_beat;
    logic              beat1;
    logic              accept;
    logic              finish;
    logic [ADDR_W-1:0] beat_addr;
    logic [31:0]       wr_din;
    logic [31:0]       wr_dout;
    logic [3:0]        wr_be;
    logic [31:0]       rd_dout;
    logic [3:0]        rd_be;

    assign beat1   = (state == S_BEAT1);
    assign in_beat = (state == S_BEAT0) || beat1;
    assign accept  = (state == S_IDLE) && req && !mfc_q;
    // Completion is reported only while the request is still held.
    assign finish  = req && ((state == S_DONE) || (state == S_ERR));

    // Second beat sits one word above the first; wraps with ADDR_W.
    assign beat_addr = {addr_q[ADDR_W-1:2], 2'b00}
                     + (beat1 ? ADDR_W'(4) : '0);
    assign wr_din    = beat1 ? wdata_q[63:32] : wdata_q[31:0];

    lsu_lane_align #(.LOAD(1'b0)) u_wr_align (
        .dtype (dtype_q),
        .off   (addr_q[1:0]),
        .sext  (sext_q),
        .din   (wr_din),
        .dout  (wr_dout),
        .be    (wr_be)
    );

    lsu_lane_align #(.LOAD(1'b1)) u_rd_align (
        .dtype (dtype_q),
        .off   (addr_q[1:0]),
        .sext  (sext_q),
        .din   (mem_rdata),
        .dout  (rd_dout),
        .be    (rd_be)
    );

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (accept) state_n = S_CHECK;
            end
            S_CHECK: begin
                if (!req)
                    state_n = S_IDLE;
                else if (misaligned(dtype_q, addr_q[1:0]))
                    state_n = S_ERR;
                else
                    state_n = S_BEAT0;
            end
            S_BEAT0, S_BEAT1: begin
                if (mem_ready) begin
                    if (!req)
                        state_n = S_IDLE;
                    else if (!beat1 && dtype_q == DT_DWORD)
                        state_n = S_BEAT1;
                    else
                        state_n = S_DONE;
                end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                    state_n = req ? S_ERR : S_IDLE;
                end
            end
            S_DONE, S_ERR: begin
                if (!req) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= S_IDLE;
            rd_q     <= 1'b0;
            dtype_q  <= DT_BYTE;
            sext_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            wait_cnt <= '0;
            mfc_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                rd_q    <= rd;
                dtype_q <= dtype;
                sext_q  <= sext;
                addr_q  <= addr;
                wdata_q <= wdata;
                rdata_q <= '0;
            end
            // Restarts at zero on every beat entry.
            if (in_beat && !mem_ready && state_n == state)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (in_beat && mem_ready && rd_q) begin
                if (beat1)
                    rdata_q[63:32] <= mem_rdata;
                else
                    rdata_q[31:0] <= rd_dout;
            end
            mfc_q  <= finish;
            err_q  <= req && (state == S_ERR);
            busy_q <= (state_n != S_IDLE) && !finish;
        end
    end

    assign mfc       = mfc_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign rdata     = (state == S_DONE) ? rdata_q : '0;
    assign mem_en    = in_beat;
    assign mem_rw    = in_beat && rd_q;
    assign mem_addr  = in_beat ? beat_addr : '0;
    assign mem_wdata = (in_beat && !rd_q) ? wr_dout : '0;
    assign mem_be    = in_beat ? (rd_q ? rd_be : wr_be) : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed corner cases plus
// random accesses against a byte-array memory reference model.
module tb_load_store_unit;

    logic        clk;
    logic        clr;
    logic        req;
    logic        rd;
    logic [1:0]  dtype;
    logic        sext;
    logic [7:0]  addr;
    logic [63:0] wdata;
    logic        mfc;
    logic        err;
    logic [63:0] rdata;
    logic        busy;
    logic        mem_en;
    logic        mem_rw;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    load_store_unit #(.ADDR_W(8), .TIMEOUT(15)) dut (
        .clk       (clk),
        .clr       (clr),
        .req       (req),
        .rd        (rd),
        .dtype     (dtype),
        .sext      (sext),
        .addr      (addr),
        .wdata     (wdata),
        .mfc       (mfc),
        .err       (err),
        .rdata     (rdata),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic       mem_sync = 1'b0;
    logic       noise_en = 1'b0;
    int         ready_delay = 0;
    int         dly_cnt = 0;
    logic [7:0]  last_addr;
    logic [3:0]  last_be;
    logic [31:0] last_wdata;
    logic [7:0]  beat_q [$];

    // Memory responder: grants each beat after ready_delay wait cycles.
    always @(negedge clk) begin
        if (mem_sync)
            for (int i = 0; i < 256; i++) mem[i] = ref_mem[i];
        if (mem_en && dly_cnt >= ready_delay) begin
            mem_ready  = 1'b1;
            last_addr  = mem_addr;
            last_be    = mem_be;
            last_wdata = mem_wdata;
            beat_q.push_back(mem_addr);
            if (mem_rw)
                mem_rdata = {mem[mem_addr + 8'd3], mem[mem_addr + 8'd2],
                             mem[mem_addr + 8'd1], mem[mem_addr]};
            else
                for (int i = 0; i < 4; i++)
                    if (mem_be[i]) mem[mem_addr + 8'(i)] = mem_wdata[8*i +: 8];
            dly_cnt = 0;
        end else if (mem_en) begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            dly_cnt++;
        end else begin
            mem_ready = noise_en ? 1'($urandom) : 1'b0;
            mem_rdata = $urandom;
            dly_cnt = 0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sync_mem();
        mem_sync = 1'b1;
        @(negedge clk);
        #1 mem_sync = 1'b0;
    endtask

    function automatic bit mem_equal();
        for (int i = 0; i < 256; i++)
            if (mem[i] !== ref_mem[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit exp_mis(input logic [7:0] a, input logic [1:0] dt);
        if (dt == 2'd0) return 1'b0;
        if (dt == 2'd1) return a[0];
        return a[1:0] != 2'b00;
    endfunction

    function automatic logic [63:0] exp_load(input logic [7:0] a,
                                             input logic [1:0] dt,
                                             input logic sx);
        logic [63:0] v;
        logic [15:0] h;
        v = '0;
        h = {ref_mem[a + 8'd1], ref_mem[a]};
        case (dt)
            2'd0: v[31:0] = {{24{sx & ref_mem[a][7]}}, ref_mem[a]};
            2'd1: v[31:0] = {{16{sx & h[15]}}, h};
            2'd2: for (int i = 0; i < 4; i++) v[8*i +: 8] = ref_mem[a + 8'(i)];
            default: for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_mem[a + 8'(i)];
        endcase
        return v;
    endfunction

    task automatic ref_store(input logic [7:0] a, input logic [1:0] dt,
                             input logic [63:0] wd);
        for (int i = 0; i < (1 << dt); i++) ref_mem[a + 8'(i)] = wd[8*i +: 8];
    endtask

    // One full four-phase access; lat counts edges from req to mfc.
    task automatic run(input logic r, input logic [1:0] dt, input logic sx,
                       input logic [7:0] a, input logic [63:0] wd, input int dly,
                       output logic [63:0] rv, output logic ev,
                       output int lat, output int en_cyc);
        bit seen;
        seen = 1'b0;
        lat = 0;
        en_cyc = 0;
        @(posedge clk);
        #1;
        ready_delay = dly;
        rd = r; dtype = dt; sext = sx; addr = a; wdata = wd;
        req = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (mem_en) en_cyc++;
            if (mfc) begin
                lat = c;
                seen = 1'b1;
                break;
            end
        end
        check("mfc_seen", 64'(seen), 64'd1);
        rv = rdata;
        ev = err;
        req = 1'b0;
        @(posedge clk);
        #1;
        check("mfc_clear", 64'(mfc), 64'd0);
        check("err_clear", 64'(err), 64'd0);
    endtask

    initial begin
        logic [63:0] rv;
        logic        ev;
        int          lat;
        int          en_cyc;
        bit          found;
        bit          saw_mfc;
        logic        r;
        logic [1:0]  dt;
        logic        sx;
        logic [7:0]  a;
        logic [63:0] wd;
        int          d;
        logic [63:0] er;

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
        clr = 1'b0; req = 1'b0; rd = 1'b0; dtype = 2'd0;
        sext = 1'b0; addr = '0; wdata = '0;
        sync_mem();
        @(posedge clk);
        #1;
        check("rst_mfc", 64'(mfc), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mem_en", 64'(mem_en), 64'd0);
        check("rst_rdata", rdata, 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_mem_be", 64'(mem_be), 64'd0);
        #3 clr = 1'b1;

        // Reset during the second beat of a doubleword load.
        @(posedge clk);
        #1;
        ready_delay = 2;
        rd = 1'b1; dtype = 2'd3; sext = 1'b0; addr = 8'h10; req = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            if (mem_en && mem_addr == 8'h14) begin
                found = 1'b1;
                break;
            end
        end
        check("t1_reach_beat1", 64'(found), 64'd1);
        #1 clr = 1'b0;
        #1;
        check("t1_mem_en", 64'(mem_en), 64'd0);
        check("t1_busy", 64'(busy), 64'd0);
        check("t1_mfc", 64'(mfc), 64'd0);
        req = 1'b0;
        #4 clr = 1'b1;
        run(1'b1, 2'd2, 1'b0, 8'h20, '0, 1, rv, ev, lat, en_cyc);
        check("t1_after_rdata", rv, exp_load(8'h20, 2'd2, 1'b0));
        check("t1_after_lat", 64'(lat), 64'd5);

        // Signed byte load from the top lane.
        ref_mem[0] = 8'h12; ref_mem[1] = 8'hFF;
        ref_mem[2] = 8'hFF; ref_mem[3] = 8'h80;
        sync_mem();
        run(1'b1, 2'd0, 1'b1, 8'h03, '0, 0, rv, ev, lat, en_cyc);
        check("t2_rdata", rv, 64'h0000_0000_FFFF_FF80);
        check("t2_be", 64'(last_be), 64'hF);
        check("t2_lat", 64'(lat), 64'd4);
        check("t2_err", 64'(ev), 64'd0);

        // Halfword store to the upper half of a word.
        run(1'b0, 2'd1, 1'b0, 8'h06, 64'h0000_0000_0000_BEEF, 0,
            rv, ev, lat, en_cyc);
        ref_store(8'h06, 2'd1, 64'h0000_0000_0000_BEEF);
        check("t3_addr", 64'(last_addr), 64'h04);
        check("t3_be", 64'(last_be), 64'hC);
        check("t3_wdata", 64'(last_wdata), 64'hBEEF_BEEF);
        check("t3_err", 64'(ev), 64'd0);
        check("t3_mem", 64'(mem_equal()), 64'd1);

        // Doubleword load wrapping past the top of the address space.
        beat_q.delete();
        run(1'b1, 2'd3, 1'b0, 8'hFC, '0, 0, rv, ev, lat, en_cyc);
        check("t4_beats", 64'(beat_q.size()), 64'd2);
        if (beat_q.size() == 2) begin
            check("t4_beat0", 64'(beat_q[0]), 64'hFC);
            check("t4_beat1", 64'(beat_q[1]), 64'h00);
        end
        check("t4_rdata", rv, exp_load(8'hFC, 2'd3, 1'b0));
        check("t4_lat", 64'(lat), 64'd5);

        // Misaligned word load.
        run(1'b1, 2'd2, 1'b0, 8'h02, '0, 0, rv, ev, lat, en_cyc);
        check("t5_err", 64'(ev), 64'd1);
        check("t5_en_cycles", 64'(en_cyc), 64'd0);
        check("t5_rdata", rv, 64'd0);
        check("t5_lat", 64'(lat), 64'd3);

        // Memory never answers.
        run(1'b1, 2'd2, 1'b0, 8'h40, '0, 1000, rv, ev, lat, en_cyc);
        check("t6_en_cycles", 64'(en_cyc), 64'd15);
        check("t6_err", 64'(ev), 64'd1);
        check("t6_rdata", rv, 64'd0);
        check("t6_lat", 64'(lat), 64'd18);

        // Request withdrawn mid-beat: no completion reported.
        @(posedge clk);
        #1;
        ready_delay = 5;
        rd = 1'b1; dtype = 2'd2; addr = 8'h30; req = 1'b1;
        repeat (3) @(posedge clk);
        #1 req = 1'b0;
        saw_mfc = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (mfc) saw_mfc = 1'b1;
            if (!busy && !mem_en) begin
                found = 1'b1;
                break;
            end
        end
        check("abort_idle", 64'(found), 64'd1);
        check("abort_no_mfc", 64'(saw_mfc), 64'd0);

        // Random accesses against the byte-array model.
        noise_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            r  = 1'($urandom);
            dt = 2'($urandom);
            sx = 1'($urandom);
            a  = 8'($urandom);
            if ($urandom_range(3) != 0) a = a & ~((8'd1 << dt) - 8'd1);
            wd = {$urandom, $urandom};
            d  = $urandom_range(3);
            er = exp_load(a, dt, sx);
            run(r, dt, sx, a, wd, d, rv, ev, lat, en_cyc);
            if (exp_mis(a, dt)) begin
                check("rnd_mis_err", 64'(ev), 64'd1);
                check("rnd_mis_en", 64'(en_cyc), 64'd0);
                check("rnd_mis_lat", 64'(lat), 64'd3);
            end else begin
                check("rnd_err", 64'(ev), 64'd0);
                check("rnd_lat", 64'(lat),
                      (dt == 2'd3) ? 64'(5 + 2 * d) : 64'(4 + d));
                if (r) begin
                    check("rnd_rdata", rv, er);
                end else begin
                    ref_store(a, dt, wd);
                    check("rnd_mem", 64'(mem_equal()), 64'd1);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
